// File: rtl/mem_wb_stage.sv
// MEM/WB stage of the RV32I core: waits on load responses, lane-aligns them and drives the regfile write port.
// Optional EX-stage forwarding mirror on fwd_* is enabled by defining WB_FWD_EN (otherwise fwd_* read 0).
module mem_wb_stage #(
  parameter int LOAD_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd_addr,
  input  logic [31:0] in_result,
  input  logic        in_reg_write,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_opcode,
  input  logic        dm_rsp_valid,
  input  logic [31:0] dm_rdata,
  output logic [4:0]  WB_rd_addr,
  output logic [31:0] WB_rd_data,
  output logic        RegWrite,
  output logic [2:0]  funct3,
  output logic [6:0]  opcode,
  output logic        load_err,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_data
);

  localparam int          CNT_W   = $clog2(LOAD_TIMEOUT + 1);
  localparam logic [6:0]  OP_LOAD = 7'b0000011;

  typedef enum logic {IDLE, WAIT_LOAD} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [4:0]        ld_rd_q, ld_rd_d;
  logic [2:0]        ld_funct3_q, ld_funct3_d;
  logic [6:0]        ld_opcode_q, ld_opcode_d;
  logic [1:0]        ld_off_q, ld_off_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic              reg_write_q, reg_write_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [6:0]        opcode_q, opcode_d;
  logic              load_err_q, load_err_d;
  logic [31:0]       lane_shift [4];
  logic [31:0]       load_aligned;

  // Candidate word for each byte lane moved down to bit 0.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_shift[gi] = dm_rdata >> (8 * gi);
  end

  always_comb begin
    case (ld_funct3_q)
      3'b000, 3'b100: load_aligned = lane_shift[ld_off_q];
      3'b001, 3'b101: load_aligned = lane_shift[{ld_off_q[1], 1'b0}];
      default:        load_aligned = dm_rdata;
    endcase
  end

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ld_rd_d     = ld_rd_q;
    ld_funct3_d = ld_funct3_q;
    ld_opcode_d = ld_opcode_q;
    ld_off_d    = ld_off_q;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    funct3_d    = funct3_q;
    opcode_d    = opcode_q;
    reg_write_d = 1'b0;
    load_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_opcode == OP_LOAD) begin
            ld_rd_d     = in_rd_addr;
            ld_funct3_d = in_funct3;
            ld_opcode_d = in_opcode;
            ld_off_d    = in_result[1:0];
            cnt_d       = '0;
            state_d     = WAIT_LOAD;
          end else begin
            wb_rd_d     = in_rd_addr;
            wb_data_d   = in_result;
            funct3_d    = in_funct3;
            opcode_d    = in_opcode;
            reg_write_d = in_reg_write && (in_rd_addr != 5'd0);
          end
        end
      end
      WAIT_LOAD: begin
        // A response arriving in the expiry cycle takes priority over the timeout.
        if (dm_rsp_valid) begin
          wb_rd_d     = ld_rd_q;
          wb_data_d   = load_aligned;
          funct3_d    = ld_funct3_q;
          opcode_d    = ld_opcode_q;
          reg_write_d = (ld_rd_q != 5'd0);
          cnt_d       = '0;
          state_d     = IDLE;
        end else if (cnt_inc == CNT_W'(LOAD_TIMEOUT)) begin
          load_err_d  = 1'b1;
          cnt_d       = '0;
          state_d     = IDLE;
        end else begin
          cnt_d       = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ld_rd_q     <= '0;
      ld_funct3_q <= '0;
      ld_opcode_q <= '0;
      ld_off_q    <= '0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      funct3_q    <= '0;
      opcode_q    <= '0;
      reg_write_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ld_rd_q     <= ld_rd_d;
      ld_funct3_q <= ld_funct3_d;
      ld_opcode_q <= ld_opcode_d;
      ld_off_q    <= ld_off_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      funct3_q    <= funct3_d;
      opcode_q    <= opcode_d;
      reg_write_q <= reg_write_d;
      load_err_q  <= load_err_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign WB_rd_addr = wb_rd_q;
  assign WB_rd_data = wb_data_q;
  assign RegWrite   = reg_write_q;
  assign funct3     = funct3_q;
  assign opcode     = opcode_q;
  assign load_err   = load_err_q;

`ifdef WB_FWD_EN
  assign fwd_valid = reg_write_q;
  assign fwd_rd    = wb_rd_q;
  assign fwd_data  = wb_data_q;
`else
  assign fwd_valid = 1'b0;
  assign fwd_rd    = 5'd0;
  assign fwd_data  = 32'd0;
`endif

endmodule
